operand_dispatcher: RTL and testbench

- Upstream feeder for the 16-lane unary dot-product array (product blocks plus parallel accumulator).
- Accepts a stream of 4-bit (w, x) operand pairs over a valid/ready handshake and packs them into a 16-lane batch, padding short vectors.
- Normalises zero operands and issues the batch to all lanes with a single-cycle `in_rdy` pulse.
- Tracks the lanes' `done` signals to report batch completion, and double-buffers so the next batch fills while the current one computes.

---
 rtl/operand_dispatcher.sv | 100 ++++++++++
 tb/tb_operand_dispatcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_dispatcher.sv
// Packs a stream of (w, x) operand pairs into a LANES-wide batch, issues it with a one-cycle
// in_rdy strobe and tracks lane completion. Define OPERAND_SWAP_EN to put the smaller operand on w.
module operand_dispatcher #(
    parameter int LANES = 16,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_w,
    input  logic [WIDTH-1:0]             s_x,
    input  logic                         s_last,
    output logic [LANES-1:0]             in_rdy,
    output logic [LANES-1:0][WIDTH-1:0]  w,
    output logic [LANES-1:0][WIDTH-1:0]  x,
    input  logic [LANES-1:0]             lane_done,
    output logic                         busy,
    output logic                         batch_done
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [PW-1:0]    ptr;
    logic             full;
    logic             accept;
    logic             close;
    logic             issue;
    logic [WIDTH-1:0] nw;
    logic [WIDTH-1:0] nx;

    assign s_ready    = !full;
    assign accept     = s_valid && !full;
    assign close      = accept && (s_last || ptr == PW'(LANES - 1));
    assign issue      = full && !busy;
    assign in_rdy     = {LANES{issue}};
    // busy is still low in the issue cycle, so lane_done is ignored there
    assign batch_done = busy && (&lane_done);

    // A zero operand becomes (1,0): w=0 would wrap the lane counter, (1,0) finishes at once.
    // The swap only touches non-zero pairs so a normalised pair never ends up with w=0.
    always_comb begin
        nw = s_w;
        nx = s_x;
        if (s_w == '0 || s_x == '0) begin
            nw = WIDTH'(1);
            nx = '0;
        end
`ifdef OPERAND_SWAP_EN
        else if (s_w > s_x) begin
            nw = s_x;
            nx = s_w;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            full <= 1'b0;
        end else begin
            if (close) begin
                full <= 1'b1;
                ptr  <= '0;
            end else if (accept) begin
                ptr <= ptr + 1'b1;
            end
            if (issue)
                full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= 1'b0;
        else if (issue)
            busy <= 1'b1;
        else if (batch_done)
            busy <= 1'b0;
    end

    // The staging buffer drives w/x directly; lanes only sample it while in_rdy is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w <= '0;
            x <= '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (PW'(i) == ptr) begin
                    w[i] <= nw;
                    x[i] <= nx;
                end else if (close && PW'(i) > ptr) begin
                    w[i] <= WIDTH'(1);
                    x[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_dispatcher.sv
// Directed bench for operand_dispatcher with a behavioural unary product/accumulator model.
module tb_operand_dispatcher;

    localparam int LANES = 16;
    localparam int WIDTH = 4;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic                        s_valid = 1'b0;
    logic                        s_ready;
    logic [WIDTH-1:0]            s_w = '0;
    logic [WIDTH-1:0]            s_x = '0;
    logic                        s_last = 1'b0;
    logic [LANES-1:0]            in_rdy;
    logic [LANES-1:0][WIDTH-1:0] w;
    logic [LANES-1:0][WIDTH-1:0] x;
    logic [LANES-1:0]            lane_done;
    logic                        busy;
    logic                        batch_done;

    operand_dispatcher #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_w(s_w), .s_x(s_x), .s_last(s_last),
        .in_rdy(in_rdy), .w(w), .x(x), .lane_done(lane_done),
        .busy(busy), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // product lanes: count w*(x+1) cycles after load; accumulator holds sum of w*x
    int cnt [LANES];
    int acc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) cnt[i] <= 0;
            acc <= 0;
        end else if (in_rdy[0]) begin
            int s;
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                cnt[i] <= int'(w[i]) * (int'(x[i]) + 1);
                s = s + int'(w[i]) * int'(x[i]);
            end
            acc <= s;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
        end
    end
    always_comb begin
        lane_done = '0;
        for (int i = 0; i < LANES; i++) lane_done[i] = (cnt[i] == 0);
    end

    // event recorder, sampled mid-cycle
    int               issue_q[$];
    int               done_q[$];
    int               dacc_q[$];
    logic             rdy_q[$];
    logic [LANES-1:0] issue_vec;
    logic [63:0]      iss_w, iss_x;
    logic             prev_issue = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_issue) rdy_q.push_back(s_ready);
            if (in_rdy != '0) begin
                issue_q.push_back(cyc);
                issue_vec = in_rdy;
                iss_w = w;
                iss_x = x;
            end
            if (batch_done) begin
                done_q.push_back(cyc);
                dacc_q.push_back(acc);
            end
            prev_issue = (in_rdy != '0);
        end else begin
            prev_issue = 1'b0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int acc_cyc = 0;
    logic [63:0] ew, ex;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        issue_q.delete();
        done_q.delete();
        dacc_q.delete();
        rdy_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ww, input logic [3:0] xx, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_w = ww;
        s_x = xx;
        s_last = last;
        while (!s_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("send_timeout", s_ready, 1);
        acc_cyc = cyc;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_q.size() < n && k < 600) begin
            tick();
            k++;
        end
        chk("done_count", done_q.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_in_rdy"}, in_rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_batch_done"}, batch_done, 0);
        chk({tag, "_w"}, w, 0);
        chk({tag, "_x"}, x, 0);
    endtask

    // one pair on lane 0, all other lanes expected padded
    task automatic exp_single(input logic [3:0] w0, input logic [3:0] x0);
        for (int i = 0; i < LANES; i++) begin
            ew[i*4 +: 4] = 4'd1;
            ex[i*4 +: 4] = 4'd0;
        end
        ew[3:0] = w0;
        ex[3:0] = x0;
    endtask

    initial begin
        // reset state
        #1;
        check_reset_outputs("reset");
        tick();
        reset = 1'b0;
        tick();

        // 16 x (3,2)
        clr();
        for (int i = 0; i < 16; i++) send(4'd3, 4'd2, 1'b0);
        wait_done(1);
        chk("b1_issue_cnt", issue_q.size(), 1);
        chk("b1_issue_lat", issue_q[0], acc_cyc + 1);
        chk("b1_in_rdy", issue_vec, 16'hFFFF);
        chk("b1_ready_after", rdy_q[0], 1);
        chk("b1_acc", dacc_q[0], 96);
        chk("b1_busy_fall", busy, 0);

        // 5 x (2,5) with last: padding
        clr();
        for (int i = 0; i < 5; i++) send(4'd2, 4'd5, i == 4);
        wait_done(1);
        exp_single(4'd2, 4'd5);
        for (int i = 1; i < 5; i++) begin
            ew[i*4 +: 4] = 4'd2;
            ex[i*4 +: 4] = 4'd5;
        end
        chk("pad_w", iss_w, ew);
        chk("pad_x", iss_x, ex);
        chk("pad_acc", dacc_q[0], 50);

        // zero operands
        clr();
        send(4'd0, 4'd7, 1'b0);
        send(4'd7, 4'd0, 1'b0);
        send(4'd0, 4'd0, 1'b0);
        send(4'd3, 4'd3, 1'b1);
        wait_done(1);
        exp_single(4'd1, 4'd0);
        ew[15:12] = 4'd3;
        ex[15:12] = 4'd3;
        chk("zero_w", iss_w, ew);
        chk("zero_x", iss_x, ex);
        chk("zero_acc", dacc_q[0], 9);

        // swap option
        clr();
        send(4'd9, 4'd2, 1'b1);
        wait_done(1);
`ifdef OPERAND_SWAP_EN
        exp_single(4'd2, 4'd9);
`else
        exp_single(4'd9, 4'd2);
`endif
        chk("swap_w", iss_w, ew);
        chk("swap_x", iss_x, ex);
        chk("swap_acc", dacc_q[0], 18);

        // second batch fills while the first computes
        clr();
        for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 1'b0);
        for (int i = 0; i < 16; i++) send(4'd1, 4'd1, 1'b0);
        chk("db_ready_low", s_ready, 0);
        chk("db_busy", busy, 1);
        wait_done(2);
        chk("db_issue_cnt", issue_q.size(), 2);
        chk("db_issue2_cyc", issue_q[1], done_q[0] + 1);
        chk("db_acc1", dacc_q[0], 3600);
        chk("db_acc2", dacc_q[1], 16);

        // reset mid-fill
        clr();
        for (int i = 0; i < 7; i++) send(4'd2, 4'd2, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_fill");
        tick();
        reset = 1'b0;
        tick();
        clr();
        send(4'd4, 4'd4, 1'b1);
        wait_done(1);
        exp_single(4'd4, 4'd4);
        chk("rst_fill_w", iss_w, ew);
        chk("rst_fill_acc", dacc_q[0], 16);

        // reset mid-compute
        clr();
        for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 1'b0);
        for (int k = 0; k < 20 && issue_q.size() == 0; k++) tick();
        chk("rst_comp_issued", issue_q.size(), 1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_comp");
        tick();
        reset = 1'b0;
        tick();
        clr();
        send(4'd2, 4'd3, 1'b1);
        wait_done(1);
        exp_single(4'd2, 4'd3);
        chk("rst_comp_w", iss_w, ew);
        chk("rst_comp_acc", dacc_q[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
